// File: rtl/multi_digit_display_controller.sv
// Scan controller for NUM_DIGITS common-anode seven-segment digits: decimal (double-dabble) or hex
// conversion, tear-free display register. Optional macro LEADING_ZERO_BLANK_EN blanks leading zeros.
module multi_digit_display_controller #(
  parameter int NUM_DIGITS   = 8,
  parameter int VALUE_WIDTH  = 16,
  parameter int COUNT_PERIOD = 100000
) (
  input  logic                   clk_in,
  input  logic                   rst_n_in,
  input  logic [VALUE_WIDTH-1:0] value_in,
  input  logic                   negative_in,
  input  logic                   hex_mode_in,
  input  logic                   valid_in,
  output logic                   ready_out,
  output logic [6:0]             cat_out,
  output logic [NUM_DIGITS-1:0]  an_out
);
  // Eight BCD digits cover the largest 24-bit value, so overflow is always detectable.
  localparam int BCD_DIGITS = 8;
  localparam int BCD_W      = 4 * BCD_DIGITS;
  localparam int MAG_DIGITS = NUM_DIGITS - 1;
  localparam int ITER_W     = $clog2(VALUE_WIDTH);
  localparam int IDX_W      = $clog2(NUM_DIGITS);
  localparam int CNT_W      = $clog2(COUNT_PERIOD);
  localparam logic [4:0] GLYPH_DASH  = 5'd16;
  localparam logic [4:0] GLYPH_BLANK = 5'd17;

  typedef enum logic {IDLE, CONVERT} state_t;

  state_t                       state_reg;
  logic                         ready_reg;
  logic                         neg_reg;
  logic [VALUE_WIDTH-1:0]       bin_reg;
  logic [BCD_W-1:0]             bcd_reg;
  logic [ITER_W-1:0]            iter_reg;
  logic [NUM_DIGITS-1:0][4:0]   glyph_reg;
  logic                         scan_active_reg;
  logic [IDX_W-1:0]             scan_idx_reg;
  logic [CNT_W-1:0]             scan_cnt_reg;

  logic                         accept;
  logic                         last_iter;
  logic                         commit;
  logic [BCD_W-1:0]             bcd_adj;
  logic [BCD_W-1:0]             bcd_next;
  logic [VALUE_WIDTH-1:0]       bin_next;
  logic [BCD_W-1:0]             commit_digits;
  logic                         commit_neg;
  logic                         overflow;
  logic [NUM_DIGITS-1:0][4:0]   glyph_next;
  logic                         unused_bcd_msb;

  function automatic logic [6:0] bto7s(input logic [4:0] glyph);
    case (glyph)
      5'd0:    return 7'h3F;
      5'd1:    return 7'h06;
      5'd2:    return 7'h5B;
      5'd3:    return 7'h4F;
      5'd4:    return 7'h66;
      5'd5:    return 7'h6D;
      5'd6:    return 7'h7D;
      5'd7:    return 7'h07;
      5'd8:    return 7'h7F;
      5'd9:    return 7'h6F;
      5'd10:   return 7'h77;
      5'd11:   return 7'h7C;
      5'd12:   return 7'h39;
      5'd13:   return 7'h5E;
      5'd14:   return 7'h79;
      5'd15:   return 7'h71;
      5'd16:   return 7'h40;
      default: return 7'h00;
    endcase
  endfunction

  assign accept    = (state_reg == IDLE) && ready_reg && valid_in;
  assign last_iter = (state_reg == CONVERT) && (iter_reg == ITER_W'(VALUE_WIDTH - 1));
  assign commit    = (accept && hex_mode_in) || last_iter;

  generate
    for (genvar gi = 0; gi < BCD_DIGITS; gi++) begin : g_dd_adj
      assign bcd_adj[4*gi +: 4] = (bcd_reg[4*gi +: 4] >= 4'd5) ? bcd_reg[4*gi +: 4] + 4'd3
                                                                : bcd_reg[4*gi +: 4];
    end
  endgenerate

  assign bcd_next       = {bcd_adj[BCD_W-2:0], bin_reg[VALUE_WIDTH-1]};
  assign bin_next       = {bin_reg[VALUE_WIDTH-2:0], 1'b0};
  assign unused_bcd_msb = bcd_adj[BCD_W-1];

  // Hex nibbles and BCD digits share one digit vector, so overflow is the same test in both modes.
  assign commit_digits = (state_reg == CONVERT) ? bcd_next : BCD_W'(value_in);
  assign commit_neg    = (state_reg == CONVERT) ? neg_reg : negative_in;
  assign overflow      = |(commit_digits >> (4 * MAG_DIGITS));

`ifdef LEADING_ZERO_BLANK_EN
  logic [NUM_DIGITS-1:1] upper_zero;
  logic [NUM_DIGITS-1:1] sign_at;

  assign upper_zero[NUM_DIGITS-1] = 1'b1;
  generate
    for (genvar gi = 1; gi < NUM_DIGITS; gi++) begin : g_zero
      if (gi < MAG_DIGITS) begin : g_z
        assign upper_zero[gi] = (commit_digits[4*MAG_DIGITS-1:4*gi] == '0);
      end
      // The sign sits just left of the most significant nonzero digit (digit 1 for zero).
      if (gi == 1) begin : g_s1
        assign sign_at[gi] = upper_zero[gi];
      end else begin : g_sn
        assign sign_at[gi] = upper_zero[gi] && !upper_zero[gi-1];
      end
    end
  endgenerate

  generate
    for (genvar gi = 0; gi < MAG_DIGITS; gi++) begin : g_mag
      if (gi == 0) begin : g_lsd
        assign glyph_next[gi] = overflow ? GLYPH_DASH : {1'b0, commit_digits[3:0]};
      end else begin : g_upper
        assign glyph_next[gi] = overflow           ? GLYPH_DASH :
                                !upper_zero[gi]    ? {1'b0, commit_digits[4*gi +: 4]} :
                                (sign_at[gi] && commit_neg) ? GLYPH_DASH : GLYPH_BLANK;
      end
    end
  endgenerate

  assign glyph_next[NUM_DIGITS-1] = (commit_neg && (overflow || sign_at[NUM_DIGITS-1]))
                                    ? GLYPH_DASH : GLYPH_BLANK;
`else
  generate
    for (genvar gi = 0; gi < MAG_DIGITS; gi++) begin : g_mag
      assign glyph_next[gi] = overflow ? GLYPH_DASH : {1'b0, commit_digits[4*gi +: 4]};
    end
  endgenerate

  assign glyph_next[NUM_DIGITS-1] = commit_neg ? GLYPH_DASH : GLYPH_BLANK;
`endif

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_reg       <= IDLE;
      ready_reg       <= 1'b0;
      neg_reg         <= 1'b0;
      bin_reg         <= '0;
      bcd_reg         <= '0;
      iter_reg        <= '0;
      glyph_reg       <= {NUM_DIGITS{GLYPH_DASH}};
      scan_active_reg <= 1'b0;
      scan_idx_reg    <= '0;
      scan_cnt_reg    <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          ready_reg <= 1'b1;
          if (accept && !hex_mode_in) begin
            state_reg <= CONVERT;
            ready_reg <= 1'b0;
            neg_reg   <= negative_in;
            bin_reg   <= value_in;
            bcd_reg   <= '0;
            iter_reg  <= '0;
          end
        end
        CONVERT: begin
          bin_reg  <= bin_next;
          bcd_reg  <= bcd_next;
          iter_reg <= iter_reg + 1'b1;
          if (last_iter) begin
            state_reg <= IDLE;
            ready_reg <= 1'b1;
          end
        end
        default: state_reg <= IDLE;
      endcase

      if (commit) begin
        glyph_reg <= glyph_next;
      end

      // Free-running once started; later commits do not restart the scan.
      if (scan_active_reg) begin
        if (scan_cnt_reg == CNT_W'(COUNT_PERIOD - 1)) begin
          scan_cnt_reg <= '0;
          scan_idx_reg <= (scan_idx_reg == IDX_W'(NUM_DIGITS - 1)) ? '0 : scan_idx_reg + 1'b1;
        end else begin
          scan_cnt_reg <= scan_cnt_reg + 1'b1;
        end
      end else if (commit) begin
        scan_active_reg <= 1'b1;
        scan_idx_reg    <= '0;
        scan_cnt_reg    <= '0;
      end
    end
  end

  always_comb begin
    an_out  = '0;
    cat_out = ~bto7s(GLYPH_DASH);
    if (scan_active_reg) begin
      an_out  = ~(NUM_DIGITS'(1) << scan_idx_reg);
      cat_out = ~bto7s(glyph_reg[scan_idx_reg]);
    end
  end

  assign ready_out = ready_reg;

endmodule

// File: tb/tb_multi_digit_display_controller.sv
// Directed bench for multi_digit_display_controller: an 8-digit and a 4-digit instance share stimulus,
// checked every cycle against a value-level model plus literal digit tables.
module tb_multi_digit_display_controller;
  localparam int ND  = 8;
  localparam int ND4 = 4;
  localparam int VW  = 16;
  localparam int CP  = 4;

  logic          clk_in      = 1'b0;
  logic          rst_n_in    = 1'b0;
  logic [VW-1:0] value_in    = '0;
  logic          negative_in = 1'b0;
  logic          hex_mode_in = 1'b0;
  logic          valid_in    = 1'b0;
  logic          ready8, ready4;
  logic [6:0]    cat8, cat4;
  logic [ND-1:0] an8;
  logic [ND4-1:0] an4;

  int errors = 0;
  int checks = 0;

  always #5 clk_in = ~clk_in;

  multi_digit_display_controller #(.NUM_DIGITS(ND), .VALUE_WIDTH(VW), .COUNT_PERIOD(CP)) dut8 (
    .clk_in(clk_in), .rst_n_in(rst_n_in), .value_in(value_in), .negative_in(negative_in),
    .hex_mode_in(hex_mode_in), .valid_in(valid_in), .ready_out(ready8), .cat_out(cat8), .an_out(an8));

  multi_digit_display_controller #(.NUM_DIGITS(ND4), .VALUE_WIDTH(VW), .COUNT_PERIOD(CP)) dut4 (
    .clk_in(clk_in), .rst_n_in(rst_n_in), .value_in(value_in), .negative_in(negative_in),
    .hex_mode_in(hex_mode_in), .valid_in(valid_in), .ready_out(ready4), .cat_out(cat4), .an_out(an4));

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%h want=%h t=%0t", name, got, want, $time);
    end
  endtask

  function automatic logic [6:0] seg(input int g);
    case (g)
      0: return 7'h3F;  1: return 7'h06;  2: return 7'h5B;  3: return 7'h4F;
      4: return 7'h66;  5: return 7'h6D;  6: return 7'h7D;  7: return 7'h07;
      8: return 7'h7F;  9: return 7'h6F;  10: return 7'h77; 11: return 7'h7C;
      12: return 7'h39; 13: return 7'h5E; 14: return 7'h79; 15: return 7'h71;
      16: return 7'h40;
      default: return 7'h00;
    endcase
  endfunction

  // Glyph a digit must show, derived from the value by plain arithmetic.
  function automatic int exp_glyph(input int val, input bit neg, input bit hex, input int nd, input int d);
    int base, lim, nsig, tmp, p;
    base = hex ? 16 : 10;
    lim = 1;
    for (int i = 0; i < nd - 1; i++) lim *= base;
    if (val >= lim) return (d == nd - 1) ? (neg ? 16 : 17) : 16;
    nsig = 1;
    tmp = val / base;
    while (tmp > 0) begin nsig++; tmp /= base; end
`ifdef LEADING_ZERO_BLANK_EN
    if (d == nsig) return neg ? 16 : 17;
    if (d > nsig) return 17;
`else
    if (d == nd - 1) return neg ? 16 : 17;
`endif
    p = 1;
    for (int i = 0; i < d; i++) p *= base;
    return (val / p) % base;
  endfunction

  // Transaction-level model: readiness, committed value, cycles since the scan started.
  bit m_ready, m_committed, m_neg, m_hex, p_neg;
  int m_busy, m_scan_t, m_val, p_val;

  always @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      m_ready     <= 1'b0;
      m_busy      <= 0;
      m_committed <= 1'b0;
      m_scan_t    <= 0;
    end else begin
      if (m_committed) m_scan_t <= m_scan_t + 1;
      if (m_busy > 0) begin
        m_busy <= m_busy - 1;
        if (m_busy == 1) begin
          m_val <= p_val; m_neg <= p_neg; m_hex <= 1'b0;
          m_ready <= 1'b1; m_committed <= 1'b1;
          if (!m_committed) m_scan_t <= 0;
        end
      end else if (m_ready && valid_in) begin
        if (hex_mode_in) begin
          m_val <= int'(value_in); m_neg <= negative_in; m_hex <= 1'b1; m_committed <= 1'b1;
          if (!m_committed) m_scan_t <= 0;
        end else begin
          p_val <= int'(value_in); p_neg <= negative_in; m_busy <= VW; m_ready <= 1'b0;
        end
      end else begin
        m_ready <= 1'b1;
      end
    end
  end

  always @(negedge clk_in) begin
    logic [ND-1:0]  e_an8;
    logic [ND4-1:0] e_an4;
    logic [6:0]     e_cat8, e_cat4;
    int             i8, i4;
    e_an8 = '0; e_an4 = '0; e_cat8 = 7'h3F; e_cat4 = 7'h3F;
    if (m_committed) begin
      i8 = (m_scan_t / CP) % ND;
      i4 = (m_scan_t / CP) % ND4;
      e_an8 = '1; e_an8[i8] = 1'b0;
      e_an4 = '1; e_an4[i4] = 1'b0;
      e_cat8 = ~seg(exp_glyph(m_val, m_neg, m_hex, ND, i8));
      e_cat4 = ~seg(exp_glyph(m_val, m_neg, m_hex, ND4, i4));
    end
    check("cyc_ready8", ready8, m_ready);
    check("cyc_ready4", ready4, m_ready);
    check("cyc_an8", an8, e_an8);
    check("cyc_cat8", cat8, e_cat8);
    check("cyc_an4", an4, e_an4);
    check("cyc_cat4", cat4, e_cat4);
  end

  task automatic load(input int v, input bit neg, input bit hex);
    value_in = VW'(v); negative_in = neg; hex_mode_in = hex; valid_in = 1'b1;
    @(negedge clk_in);
    valid_in = 1'b0;
    $display("load value=%0d neg=%0d hex=%0d t=%0t", v, neg, hex, $time);
  endtask

  task automatic wait_ready(input string tag);
    int n;
    n = 0;
    while (!ready8 && n < 100) begin @(negedge clk_in); n++; end
    check({tag, "_ready"}, ready8, 1);
  endtask

  // Walk the scan and compare each digit's cathodes against a literal table.
  task automatic watch(input int nd, input logic [6:0] lit [8], input string tag);
    logic [7:0] want, got;
    logic [6:0] cat;
    int n;
    for (int d = 0; d < nd; d++) begin
      want = '1; want[d] = 1'b0; n = 0;
      got = (nd == ND) ? an8 : {4'hF, an4};
      while (got !== want && n < 80) begin
        @(negedge clk_in); n++;
        got = (nd == ND) ? an8 : {4'hF, an4};
      end
      cat = (nd == ND) ? cat8 : cat4;
      check($sformatf("%s_an%0d", tag, d), got, want);
      check($sformatf("%s_cat%0d", tag, d), cat, lit[d]);
    end
  endtask

  initial begin
    logic [6:0] lit [8];
    int lowc;

    repeat (3) @(negedge clk_in);
    check("rst_an8", an8, 8'h00);
    check("rst_cat8", cat8, 7'h3F);
    check("rst_ready8", ready8, 0);
    rst_n_in = 1'b1;
    @(negedge clk_in);
    check("release_ready8", ready8, 1);
    repeat (5) @(negedge clk_in);
    check("precommit_an8", an8, 8'h00);
    check("precommit_cat4", cat4, 7'h3F);

    load(1234, 1'b0, 1'b0);
    lowc = 0;
    while (!ready8 && lowc < 40) begin lowc++; @(negedge clk_in); end
    check("dec_busy_cycles", lowc, 16);
    check("dec_first_an", an8, 8'hFE);
    check("dec_first_cat", cat8, 7'h19);
`ifdef LEADING_ZERO_BLANK_EN
    lit = '{7'h19, 7'h30, 7'h24, 7'h79, 7'h7F, 7'h7F, 7'h7F, 7'h7F};
`else
    lit = '{7'h19, 7'h30, 7'h24, 7'h79, 7'h40, 7'h40, 7'h40, 7'h7F};
`endif
    watch(ND, lit, "dec1234");
    repeat (CP) @(negedge clk_in);
    check("scan_wrap_an", an8, 8'hFE);

    load(16'hBEEF, 1'b1, 1'b1);
    check("hex_ready_kept", ready8, 1);
`ifdef LEADING_ZERO_BLANK_EN
    lit = '{7'h0E, 7'h06, 7'h06, 7'h03, 7'h3F, 7'h7F, 7'h7F, 7'h7F};
`else
    lit = '{7'h0E, 7'h06, 7'h06, 7'h03, 7'h40, 7'h40, 7'h40, 7'h3F};
`endif
    watch(ND, lit, "hexbeef");

    load(65535, 1'b0, 1'b0);
    wait_ready("ovf");
    lit = '{7'h3F, 7'h3F, 7'h3F, 7'h7F, 7'h00, 7'h00, 7'h00, 7'h00};
    watch(ND4, lit, "ovf4");

    // valid_in held high with a changing value: only 100, then 117 after the commit.
    value_in = VW'(100); negative_in = 1'b0; hex_mode_in = 1'b0; valid_in = 1'b1;
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk_in);
      if (k == 17) check("hs_ready_after_commit", ready8, 1);
      if (k == 18) check("hs_ready_reaccept", ready8, 0);
      value_in = VW'(100 + k);
    end
    valid_in = 1'b0;
    $display("handshake burst done t=%0t", $time);
    wait_ready("hs");
`ifdef LEADING_ZERO_BLANK_EN
    lit = '{7'h78, 7'h79, 7'h79, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F};
`else
    lit = '{7'h78, 7'h79, 7'h79, 7'h40, 7'h40, 7'h40, 7'h40, 7'h7F};
`endif
    watch(ND, lit, "hs117");

    load(999, 1'b0, 1'b0);
    repeat (6) @(negedge clk_in);
    #3 rst_n_in = 1'b0;
    #1;
    $display("async reset mid-convert t=%0t", $time);
    check("midrst_ready8", ready8, 0);
    check("midrst_an8", an8, 8'h00);
    check("midrst_cat8", cat8, 7'h3F);
    check("midrst_an4", an4, 4'h0);
    check("midrst_cat4", cat4, 7'h3F);
    @(negedge clk_in);
    rst_n_in = 1'b1;
    wait_ready("postrst");

    load(42, 1'b1, 1'b0);
    wait_ready("neg42");
    check("neg42_first_an", an8, 8'hFE);
`ifdef LEADING_ZERO_BLANK_EN
    lit = '{7'h24, 7'h19, 7'h3F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F};
`else
    lit = '{7'h24, 7'h19, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h3F};
`endif
    watch(ND, lit, "neg42");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/multi_digit_display_controller.md
Name: multi_digit_display_controller

Overview:
Parametrised successor to the fixed 8-digit scan controller. It accepts a binary value over a valid/ready handshake and converts it to decimal (sequential double-dabble) or hex. It holds the digits in a tear-free display register and time-multiplexes NUM_DIGITS active-low common-anode seven-segment digits. It sits between the sonar measurement path and the board display pins and drives the existing bto7s glyph decoder.

Parameters:
NUM_DIGITS, 8, number of physical digits (2..8); digit NUM_DIGITS-1 is the sign digit.
VALUE_WIDTH, 16, width of value_in (4..24).
COUNT_PERIOD, 100000, clk_in cycles each digit stays active (>=2).

Ports:
clk_in  input  1  system clock
rst_n_in  input  1  asynchronous, active-low reset
value_in  input  VALUE_WIDTH  unsigned magnitude to display
negative_in  input  1  sign flag, sampled with value_in
hex_mode_in  input  1  1 = hex, 0 = decimal; sampled with value_in
valid_in  input  1  request to load value_in
ready_out  output  1  block can accept a new value
cat_out  output  7  segment cathodes {g..a}, active-low
an_out  output  NUM_DIGITS  digit anodes, active-low

Behaviour:
- One clock. Reset is asynchronous and active-low. All flops clear immediately on rst_n_in low, including mid-conversion.
- Reset values: ready_out 0 while reset is asserted, 1 from the first edge after release. an_out all 0 (all digits on). cat_out 7'b0111111 (dash on every digit).
- Glyph codes into bto7s: 0-15 are hex digits, 16 is dash, 17 is blank.
- FSM states: IDLE, CONVERT.
  - IDLE: ready_out=1. On valid_in && ready_out, capture value_in, negative_in and hex_mode_in.
    - Decimal: go to CONVERT.
    - Hex: commit at the next edge and stay in IDLE.
  - CONVERT: ready_out=0. Performs exactly VALUE_WIDTH shift-add-3 iterations, one per cycle. valid_in is ignored. At the last iteration edge it commits and returns to IDLE, so ready_out is 1 in the following cycle.
- Latency: decimal commit occurs VALUE_WIDTH edges after the accept edge; hex commit occurs 1 edge after.
- Commit writes all digit glyphs atomically into the display register. The scanner never shows a half-updated value.
- Magnitude digits 0..NUM_DIGITS-2:
  - Decimal: BCD digits, least significant at digit 0.
  - Hex: nibbles of the value.
  - Leading zeros are shown as 0.
- Overflow: if the value needs more than NUM_DIGITS-1 digits, all magnitude digits show dash.
  - Decimal overflow: value > 10^(NUM_DIGITS-1)-1.
  - Hex overflow: any nonzero bit at or above 4*(NUM_DIGITS-1).
- Sign digit: dash if negative_in was captured as 1, blank otherwise.
- Scanner:
  - Inactive until the first commit after reset; all-dash output persists until then.
  - From the first commit edge: digit 0 is active (an_out = ~one-hot).
  - Advances to the next digit after COUNT_PERIOD cycles and wraps from NUM_DIGITS-1 to 0.
  - The scan counter is free-running and is not reset by later commits or conversions.
- cat_out = ~bto7s(glyph of active digit), combinational from registered state.
- Simultaneous valid_in with commit: the accept happens only once ready_out=1, i.e. the cycle after a decimal commit. No back-to-back accept in CONVERT.

Optional Feature:
LEADING_ZERO_BLANK_EN.
- Defined: leading zero magnitude digits render blank, except digit 0, which always shows a value. The sign dash moves to the digit immediately left of the most significant nonzero digit (digit 1 for value 0). Digit NUM_DIGITS-1 is then blank unless the sign lands there. Overflow dashes are unchanged.
- Undefined: leading zeros are shown and the sign stays on digit NUM_DIGITS-1.

Test Plan:
(Bench parameters: NUM_DIGITS=8, VALUE_WIDTH=16, COUNT_PERIOD=4, macro undefined unless noted.)
- Reset: rst_n_in low, then release -> an_out=8'h00, cat_out=7'b0111111 until the first commit; ready_out=1 one edge after release.
- Decimal load: value 1234, negative 0, valid for one cycle -> ready_out low for exactly 16 cycles. Digits 7..0 = blank,0,0,0,1,2,3,4. First scanned digit is 0 (an_out=8'hFE, cat_out=~bto7s(4)). Digit advances every 4 cycles; after digit 7 the scan wraps to digit 0.
- Hex load: 0xBEEF, negative 1, hex_mode 1 -> commit one edge after accept. Digits 7..0 = dash,0,0,0,B,E,E,F.
- Overflow: NUM_DIGITS=4, decimal 65535 -> digits 2..0 dash; digit 3 blank for negative 0.
- Handshake and integrity: valid_in held high through CONVERT with a changing value -> only the first value is accepted. The display shows the old value until the commit edge, then the new value on all digits in the same cycle.
- Reset mid-CONVERT (cycle 7 of 16): outputs return to the reset values asynchronously. With LEADING_ZERO_BLANK_EN defined, -42 decimal -> digits 7..0 = blank×5, dash, 4, 2.
